// File: rtl/mux_pkg.sv
// Shared constants for the pixel-source selector family.
package mux_pkg;

    localparam int PIX_W = 6;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_PRIO  = 1'b1;

endpackage

// File: rtl/prio_enc_n.sv
// Lowest-index-wins priority encoder over an N-bit valid vector.
module prio_enc_n #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    logic [IDX_W-1:0] idx_s;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_s = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx_s = valid[i] ? IDX_W'(i) : idx_s;
        end
    end

    assign idx       = idx_s;
    assign any_valid = |valid;

endmodule

// File: rtl/mux_n_sync.sv
// N-channel pixel-source selector with registered output, priority compositing
// and select changes deferred to a frame/line boundary.
module mux_n_sync
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = PIX_W,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_req,
    input  logic                      sel_load,
    input  logic                      boundary,
    input  logic                      blank,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          sel_active,
    output logic                      switch_pending,
    output logic                      sel_err
);

    // One extra bit so CHANNELS itself is representable for the range check.
    localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0] sel_active_r;
    logic [SEL_W-1:0] pending_r;
    logic             switch_pending_r;
    logic             sel_err_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;

    logic             req_ok_s;
    logic             load_ok_s;
    logic             load_bad_s;
    logic [SEL_W-1:0] prio_idx_s;
    logic             prio_any_s;
    logic [WIDTH-1:0] next_data_s;
    logic             next_valid_s;

    assign req_ok_s   = ({1'b0, sel_req} < CH_LIM);
    assign load_ok_s  = sel_load & req_ok_s;
    assign load_bad_s = sel_load & ~req_ok_s;

    prio_enc_n #(
        .N     (CHANNELS),
        .IDX_W (SEL_W)
    ) u_prio (
        .valid     (in_valid),
        .idx       (prio_idx_s),
        .any_valid (prio_any_s)
    );

    // Select bookkeeping: a load waits for a boundary unless both arrive together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_active_r     <= {SEL_W{1'b0}};
            pending_r        <= {SEL_W{1'b0}};
            switch_pending_r <= 1'b0;
            sel_err_r        <= 1'b0;
        end else begin
            if (load_bad_s) begin
                sel_err_r <= 1'b1;
            end
            if (boundary && load_ok_s) begin
                sel_active_r     <= sel_req;
                switch_pending_r <= 1'b0;
            end else if (boundary && switch_pending_r) begin
                sel_active_r     <= pending_r;
                switch_pending_r <= 1'b0;
            end else if (load_ok_s) begin
                pending_r        <= sel_req;
                switch_pending_r <= 1'b1;
            end
        end
    end

    // Next output word; blank overrides both selection modes.
    always_comb begin
        next_data_s  = {WIDTH{1'b0}};
        next_valid_s = 1'b0;
        if (blank) begin
            next_data_s  = {WIDTH{1'b0}};
            next_valid_s = 1'b0;
        end else begin
            case (mode)
                MODE_FIXED: begin
                    next_data_s  = in_data[int'(sel_active_r)*WIDTH +: WIDTH];
                    next_valid_s = in_valid[sel_active_r];
                end
                MODE_PRIO: begin
                    if (prio_any_s) begin
                        next_data_s  = in_data[int'(prio_idx_s)*WIDTH +: WIDTH];
                        next_valid_s = 1'b1;
                    end else begin
                        next_data_s  = {WIDTH{1'b0}};
                        next_valid_s = 1'b0;
                    end
                end
                default: begin
                    next_data_s  = {WIDTH{1'b0}};
                    next_valid_s = 1'b0;
                end
            endcase
        end
    end

    // Output register stage feeding the VGA output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_data_r  <= next_data_s;
            out_valid_r <= next_valid_s;
        end
    end

    assign out_data       = out_data_r;
    assign out_valid      = out_valid_r;
    assign sel_active     = sel_active_r;
    assign switch_pending = switch_pending_r;
    assign sel_err        = sel_err_r;

endmodule

// File: tb/tb_mux_n_sync.sv
// Self-checking bench for mux_n_sync (5-channel build so out-of-range selects are reachable).
module tb_mux_n_sync;

    localparam int CH = 5;
    localparam int W  = 6;
    localparam int SW = $clog2(CH);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH*W-1:0] in_data = '0;
    logic [CH-1:0]   in_valid = '0;
    logic            mode = 1'b0;
    logic [SW-1:0]   sel_req = '0;
    logic            sel_load = 1'b0;
    logic            boundary = 1'b0;
    logic            blank = 1'b0;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic [SW-1:0]   sel_active;
    logic            switch_pending;
    logic            sel_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the spec says the select logic holds.
    int     m_active = 0;
    int     m_pend   = 0;
    bit     m_has    = 1'b0;
    bit     m_err    = 1'b0;
    logic [W-1:0] e_data  = '0;
    logic         e_valid = 1'b0;

    mux_n_sync #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .mode           (mode),
        .sel_req        (sel_req),
        .sel_load       (sel_load),
        .boundary       (boundary),
        .blank          (blank),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .sel_active     (sel_active),
        .switch_pending (switch_pending),
        .sel_err        (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] chan(input int i);
        return in_data[i*W +: W];
    endfunction

    task automatic model_reset();
        m_active = 0; m_pend = 0; m_has = 1'b0; m_err = 1'b0;
        e_data = '0; e_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".data"},    32'(out_data),       32'(e_data));
        check_eq({tag, ".valid"},   32'(out_valid),      32'(e_valid));
        check_eq({tag, ".active"},  32'(sel_active),     32'(m_active));
        check_eq({tag, ".pending"}, 32'(switch_pending), 32'(m_has));
        check_eq({tag, ".err"},     32'(sel_err),        32'(m_err));
    endtask

    // Apply the current inputs for one clock, advance the model, and compare.
    task automatic cycle(input string tag);
        bit found;
        bit ok;
        found = 1'b0;
        if (blank) begin
            e_data = '0; e_valid = 1'b0;
        end else if (mode) begin
            e_data = '0; e_valid = 1'b0;
            for (int i = 0; i < CH; i++) begin
                if (!found && in_valid[i]) begin
                    found = 1'b1; e_data = chan(i); e_valid = 1'b1;
                end
            end
        end else begin
            e_data = chan(m_active); e_valid = in_valid[m_active];
        end
        ok = sel_load && (int'(sel_req) < CH);
        if (sel_load && !ok) m_err = 1'b1;
        if (boundary && ok) begin
            m_active = int'(sel_req); m_has = 1'b0;
        end else if (boundary && m_has) begin
            m_active = m_pend; m_has = 1'b0;
        end else if (ok) begin
            m_pend = int'(sel_req); m_has = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
        sel_load = 1'b0;
        boundary = 1'b0;
    endtask

    initial begin
        // Channel 0..4 = 15, 03, 0C, 30, 2A
        in_data = {6'h2A, 6'h30, 6'h0C, 6'h03, 6'h15};
        in_valid = 5'b11111;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        rst = 1'b0;

        cycle("idle");
        check_eq("idle_out", 32'(out_data), 32'h15);
        check_eq("idle_sel", 32'(sel_active), 32'd0);

        sel_req = 3'd2; sel_load = 1'b1;
        cycle("load2");
        check_eq("load2_pend", 32'(switch_pending), 32'd1);
        check_eq("load2_out", 32'(out_data), 32'h15);
        cycle("wait2");
        boundary = 1'b1;
        cycle("bnd2");
        check_eq("bnd2_sel", 32'(sel_active), 32'd2);
        check_eq("bnd2_old", 32'(out_data), 32'h15);
        cycle("after2");
        check_eq("after2_out", 32'(out_data), 32'h0C);

        sel_req = 3'd3; sel_load = 1'b1; boundary = 1'b1;
        cycle("both3");
        check_eq("both3_sel", 32'(sel_active), 32'd3);
        check_eq("both3_pend", 32'(switch_pending), 32'd0);
        cycle("after3");
        check_eq("after3_out", 32'(out_data), 32'h30);

        sel_req = 3'd5; sel_load = 1'b1;
        cycle("bad5");
        check_eq("bad5_err", 32'(sel_err), 32'd1);
        check_eq("bad5_sel", 32'(sel_active), 32'd3);
        boundary = 1'b1;
        cycle("bad5_bnd");
        check_eq("bad5_sticky", 32'(sel_err), 32'd1);
        check_eq("bad5_out", 32'(out_data), 32'h30);

        mode = 1'b1; in_valid = 5'b01010;
        cycle("prio");
        check_eq("prio_out", 32'(out_data), 32'h03);
        check_eq("prio_vld", 32'(out_valid), 32'd1);
        in_valid = 5'b00000;
        cycle("prio_none");
        check_eq("prio_none_out", 32'(out_data), 32'd0);
        check_eq("prio_none_vld", 32'(out_valid), 32'd0);

        mode = 1'b0; in_valid = 5'b11111; blank = 1'b1;
        cycle("blank");
        check_eq("blank_out", 32'(out_data), 32'd0);
        blank = 1'b0;

        // Mid-cycle async reset with a pending select.
        sel_req = 3'd1; sel_load = 1'b1;
        cycle("load1");
        check_eq("load1_pend", 32'(switch_pending), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        rst = 1'b0;
        boundary = 1'b1;
        cycle("post_rst_bnd");
        check_eq("post_rst_sel", 32'(sel_active), 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            in_data  = {$urandom, $urandom};
            in_valid = CH'($urandom);
            mode     = ($urandom_range(0, 3) == 0) ? ~mode : mode;
            blank    = ($urandom_range(0, 9) == 0);
            sel_req  = SW'($urandom_range(0, 7));
            sel_load = ($urandom_range(0, 3) == 0);
            boundary = ($urandom_range(0, 6) == 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_n_sync.md
Name: mux_n_sync

Overview:
- Parametrised N-channel pixel-source selector, successor to the combinational 4:1 mux.
- Sits between the pixel generators (background, sprite, text layers) and the VGA output register stage.
- Adds a registered output and a priority (layer-compositing) mode.
- Adds select changes that are deferred to a frame/line boundary, so mid-line switching never tears the image.

Parameters:
- CHANNELS, 4, number of input channels (>=2).
- WIDTH, 6, bits per channel data word (RGB222 by default).
- SEL_W, $clog2(CHANNELS), select width (derived; not overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel "pixel opaque" flag.
- mode  input  1  0 = fixed select, 1 = priority (lowest-index valid wins).
- sel_req  input  SEL_W  requested channel for fixed mode.
- sel_load  input  1  one-cycle strobe; captures sel_req as pending.
- boundary  input  1  one-cycle strobe at frame/line boundary; commits pending select.
- blank  input  1  video blanking; forces the output to zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered valid of the selected channel.
- sel_active  output  SEL_W  currently committed select.
- switch_pending  output  1  a loaded select awaits boundary.
- sel_err  output  1  sticky: sel_req >= CHANNELS was loaded.

Behaviour:
- Reset (async, immediate):
  - out_data=0, out_valid=0, sel_active=0, switch_pending=0, sel_err=0.
  - Internal pending register = 0.
- Select load:
  - sel_load with sel_req < CHANNELS: pending <= sel_req, switch_pending <= 1.
  - A later sel_load before the boundary overwrites pending (last wins).
- Invalid load:
  - sel_load with sel_req >= CHANNELS: ignored (pending and switch_pending unchanged).
  - sel_err <= 1; cleared only by rst.
- Commit:
  - boundary with switch_pending=1: sel_active <= pending, switch_pending <= 0.
  - boundary with no pending: no change.
- Simultaneous sel_load and boundary:
  - A valid sel_req commits directly: sel_active <= sel_req, switch_pending <= 0.
  - An invalid sel_req sets sel_err; any existing pending select still commits.
- Datapath latency is 1 cycle. Outputs at edge k+1 reflect in_data, in_valid, mode and blank sampled at edge k, plus the sel_active value held before edge k.
  - Consequence: data in the boundary cycle still uses the old select; the new select applies from the next cycle.
- Fixed mode (mode=0):
  - out_data <= in_data[sel_active], out_valid <= in_valid[sel_active].
  - Data passes through regardless of valid.
- Priority mode (mode=1):
  - Pick the lowest index i with in_valid[i]=1: out_data <= in_data[i], out_valid <= 1.
  - No valid channel: out_data <= 0, out_valid <= 0.
  - sel_active and pending logic keep running but do not affect the output.
- Blank (highest priority in the datapath): out_data <= 0, out_valid <= 0 in either mode. Select logic is unaffected.
- Mode may change on any cycle; the effect is visible 1 cycle later with no extra pipeline state.
- Reset mid-operation: pending select is discarded and the output drops to 0 immediately.

Decomposition:
- Shared package mux_pkg: PIX_W=6 constant; mode encoding constants MODE_FIXED=1'b0, MODE_PRIO=1'b1.
- Sub-module prio_enc_n:
  - Parameter N.
  - Purely combinational; in_valid -> index of lowest set bit, plus any_valid flag.
- Top module holds the select/pending registers, the output register, and the channel index mux.

Test Plan:
- Reset then idle, CHANNELS=4, in_data={6'h30,6'h0C,6'h03,6'h15}, mode=0 -> out_data=6'h15 one cycle after reset release; sel_active=0.
- Deferred switch: sel_req=2, sel_load pulse -> switch_pending=1, out_data stays 6'h15. Boundary pulse -> sel_active=2 next edge; out_data=6'h0C one further edge.
- Simultaneous load+boundary with sel_req=3 -> sel_active=3 and switch_pending=0 after one edge; out_data=6'h30 the edge after.
- Invalid select: sel_req=5 with CHANNELS=4 (SEL_W=3 via CHANNELS=5 build, or force) -> sel_err=1 stays high, sel_active unchanged, out_data unchanged.
- Priority mode: mode=1, in_valid=4'b1010 -> out_data=in_data[1]=6'h03, out_valid=1. in_valid=4'b0000 -> out_data=0, out_valid=0.
- Blank and async reset: blank=1 mid-stream -> out_data=0, out_valid=0 next edge. Assert rst between edges with switch_pending=1 -> all outputs 0 immediately; a boundary pulse after release leaves sel_active=0.
